divmod32_seq: RTL and testbench

- Sequential 32-bit unsigned divider that returns both quotient and remainder. It is the ALU's mod/div responder: the ALU control or a bench issues a start request and receives a done response.
- Uses a restoring shift-subtract algorithm with a fixed latency of WIDTH cycles, replacing unbounded repeated subtraction.
- Sits beside the combinational logic units (and32/or32/add32) in the project ALU and feeds the ALU result mux.

---
 rtl/alu_pkg.sv | 15 +
 rtl/divmod32_step.sv | 25 ++
 rtl/divmod32_seq.sv | 120 ++++++++++++
 tb/tb_divmod32_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: datapath width, divider FSM states and
// the quotient value returned for a zero divisor.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam logic [ALU_WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/divmod32_step.sv
// One restoring shift-subtract iteration (combinational).
// In: partial_rem, dividend_msb, divisor. Out: next_rem, q_bit.
module divmod32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // The extra top bit keeps the compare exact when the
    // shifted remainder no longer fits in WIDTH bits.
    assign trial = {partial_rem, dividend_msb};
    assign q_bit = (trial >= {1'b0, divisor});

    // A successful subtract leaves a value below divisor, so
    // the low WIDTH bits of the difference are exact.
    assign next_rem = q_bit ? (trial[WIDTH-1:0] - divisor)
                            : trial[WIDTH-1:0];

endmodule

// File: rtl/divmod32_seq.sv
// Sequential unsigned divider, WIDTH-cycle restoring algorithm.
// In: clk, reset, start, a, b. Out: busy, done, quotient, remainder, div_zero.
module divmod32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t       state;
    div_state_t       nstate;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] next_rem;
    logic             q_bit;
    logic             last;
    logic             b_zero;

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign b_zero = (b == '0);

    divmod32_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial_rem (rem),
        .dividend_msb(dvd[WIDTH-1]),
        .divisor     (dvs),
        .next_rem    (next_rem),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    nstate = b_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (last) begin
                    nstate = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // Quotient bits shift into the dividend register from the
    // bottom, so after WIDTH steps it holds the full quotient.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd <= a;
                        dvs <= b;
                        rem <= '0;
                        cnt <= '0;
                        if (b_zero) begin
                            quotient  <= '1;
                            remainder <= a;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    rem <= next_rem;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        quotient  <= {dvd[WIDTH-2:0], q_bit};
                        remainder <= next_rem;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmod32_seq.sv
// Self-checking bench for divmod32_seq: directed vector table
// plus held-start, operand-change and mid-flight reset sequences.
module tb_divmod32_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int npass;
    int ntot;
    logic [31:0] prev_q;
    logic [31:0] prev_r;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
    } vec_t;

    vec_t vecs[10];

    divmod32_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ez);
        int cyc;
        int bc;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'h1357_9bdf;
        b     = 32'h0000_0003;
        cyc   = 0;
        bc    = 0;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            if (cyc == 3) begin
                check("prev_q_held", quotient, prev_q);
                check("prev_r_held", remainder, prev_r);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (busy) bc++;
        check("done_seen", 32'(done), 32'd1);
        check("latency", cyc, (vb == 0) ? 32'd0 : 32'd32);
        check("busy_len", bc, (vb == 0) ? 32'd1 : 32'd33);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_zero", 32'(div_zero), 32'(ez));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("q_hold", quotient, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int hi;
        int lo;
        int dn;
        npass  = 0;
        ntot   = 0;
        prev_q = '0;
        prev_r = '0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        reset  = 1'b1;

        vecs[0] = '{32'd47, 32'd25, 32'd1, 32'd22, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vecs[3] = '{32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1};
        vecs[4] = '{32'd5, 32'd7, 32'd0, 32'd5, 1'b0};
        vecs[5] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[7] = '{32'd123456789, 32'd10000, 32'd12345, 32'd6789, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0};
        vecs[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].er, vecs[i].ez);
        end

        // start held high: accepts only from IDLE, one idle gap
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            hi = 0;
            dn = 0;
            while (busy && hi < 100) begin
                hi++;
                if (hi == 2) begin
                    a = 32'd3;
                    b = 32'd1;
                    if (k == 2) start = 1'b0;
                end
                if (hi == 20) begin
                    a = 32'd100;
                    b = 32'd7;
                end
                if (done) begin
                    dn++;
                    check("held_q", quotient, 32'd14);
                    check("held_r", remainder, 32'd2);
                end
                @(posedge clk);
                #1;
            end
            check("held_busy_len", hi, 32'd33);
            check("held_done_cnt", dn, 32'd1);
            if (k < 2) begin
                lo = 0;
                while (!busy && lo < 100) begin
                    lo++;
                    @(posedge clk);
                    #1;
                end
                check("held_idle_gap", lo, 32'd1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("held_stop", 32'(busy), 32'd0);
        prev_q = 32'd14;
        prev_r = 32'd2;

        // asynchronous reset in the middle of a request
        @(negedge clk);
        a     = 32'h4222_0225;
        b     = 32'h0202_028A;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", quotient, 32'd0);
        check("arst_r", remainder, 32'd0);
        check("arst_dz", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        check("no_done_after_rst", dn, 32'd0);
        prev_q = '0;
        prev_r = '0;
        run(32'd47, 32'd25, 32'd1, 32'd22, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
